// File: rtl/prbs_pkg.sv
// Shared constants for the x^14+x^5+x^3+x+1 PRBS checker: width, taps, seed, FSM encodings.
package prbs_pkg;

  localparam int PRBS_W = 14;
  localparam int TAP_A  = 8;
  localparam int TAP_B  = 10;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 13;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 14'h3FFF;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Next sequence bit predicted from history (hist[0] newest)
  function automatic logic prbs_pred(input logic [PRBS_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
  endfunction

endpackage

// File: rtl/prbs14_checker_if.sv
// Serial bit stream and status bundle between the link receiver and the PRBS checker.
interface prbs14_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             lost_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output bit_in, bit_valid, clr_cnt,
    input  locked, err_pulse, lost_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  bit_in, bit_valid, clr_cnt,
    output locked, err_pulse, lost_pulse, err_cnt, bit_cnt
  );
endinterface

// File: rtl/lfsr14_history.sv
// 14-bit received-bit history: shifts in either the line bit or the flywheel prediction.
module lfsr14_history
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic use_pred,
  input  logic bit_in,
  output logic pred,
  output logic all_zero
);

  logic [PRBS_W-1:0] hist_r;
  logic              pred_s;

  assign pred_s   = prbs_pred(hist_r);
  assign pred     = pred_s;
  assign all_zero = (hist_r == {PRBS_W{1'b0}});

  // History shift register, newest bit at index 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r <= {PRBS_W{1'b0}};
    end else if (shift_en) begin
      hist_r <= {hist_r[PRBS_W-2:0], (use_pred ? pred_s : bit_in)};
    end else begin
      hist_r <= hist_r;
    end
  end

endmodule

// File: rtl/prbs14_checker.sv
// PRBS14 receive checker: hunt/sync/locked FSM, windowed loss-of-lock, saturating counters.
// Define PRBS_CHK_BITCNT_EN to implement bit_cnt; otherwise bit_cnt reads 0.
module prbs14_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  prbs14_checker_if.slave  chk
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN);
  localparam int ERR_W   = $clog2(LOSS_THRESH + 1);
  localparam logic [MATCH_W-1:0] LOCK_M    = MATCH_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [ERR_W-1:0]   LOSS_E    = ERR_W'(LOSS_THRESH);
  localparam logic [3:0]         FILL_LAST = 4'(PRBS_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]         state_r, state_s;
  logic [3:0]         fill_r, fill_s;
  logic [MATCH_W-1:0] match_r, match_s, match_inc_s;
  logic [WIN_W-1:0]   win_bits_r, win_bits_s;
  logic [ERR_W-1:0]   win_errs_r, win_errs_s, errs_inc_s;
  logic               pred_s, all_zero_s, mismatch_s, use_pred_s;
  logic               err_s, lost_s;
  logic               locked_r, err_pulse_r, lost_pulse_r;
  logic [CNT_W-1:0]   err_cnt_r;

  lfsr14_history u_hist (
    .clk      (clk),
    .reset    (reset),
    .shift_en (chk.bit_valid),
    .use_pred (use_pred_s),
    .bit_in   (chk.bit_in),
    .pred     (pred_s),
    .all_zero (all_zero_s)
  );

  assign mismatch_s  = chk.bit_in ^ pred_s;
  assign match_inc_s = match_r + MATCH_W'(1);
  assign errs_inc_s  = win_errs_r + ERR_W'(mismatch_s);
  assign use_pred_s  = (state_r == ST_LOCKED);

  // Next-state, window and pulse decode for one valid bit
  always_comb begin
    state_s    = state_r;
    fill_s     = fill_r;
    match_s    = match_r;
    win_bits_s = win_bits_r;
    win_errs_s = win_errs_r;
    err_s      = 1'b0;
    lost_s     = 1'b0;
    if (chk.bit_valid) begin
      case (state_r)
        ST_HUNT: begin
          fill_s = fill_r + 4'd1;
          if (fill_r == FILL_LAST) begin
            state_s = ST_SYNC;
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (mismatch_s) begin
            match_s = {MATCH_W{1'b0}};
          end else if (all_zero_s) begin
            match_s = match_r;
          end else begin
            match_s = match_inc_s;
            if (match_inc_s == LOCK_M) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_SYNC;
            end
          end
        end
        ST_LOCKED: begin
          err_s = mismatch_s;
          if (errs_inc_s == LOSS_E) begin
            state_s    = ST_HUNT;
            fill_s     = 4'd0;
            match_s    = {MATCH_W{1'b0}};
            win_bits_s = {WIN_W{1'b0}};
            win_errs_s = {ERR_W{1'b0}};
            lost_s     = 1'b1;
          end else if (win_bits_r == WIN_LAST) begin
            win_bits_s = {WIN_W{1'b0}};
            win_errs_s = {ERR_W{1'b0}};
          end else begin
            win_bits_s = win_bits_r + WIN_W'(1);
            win_errs_s = errs_inc_s;
          end
        end
        default: begin
          state_s = ST_HUNT;
          fill_s  = 4'd0;
          match_s = {MATCH_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM, window state and registered status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_HUNT;
      fill_r       <= 4'd0;
      match_r      <= {MATCH_W{1'b0}};
      win_bits_r   <= {WIN_W{1'b0}};
      win_errs_r   <= {ERR_W{1'b0}};
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      lost_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      fill_r       <= fill_s;
      match_r      <= match_s;
      win_bits_r   <= win_bits_s;
      win_errs_r   <= win_errs_s;
      locked_r     <= (state_s == ST_LOCKED);
      err_pulse_r  <= err_s;
      lost_pulse_r <= lost_s;
    end
  end

  // Saturating error counter; clear wins, then the current error counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (chk.clr_cnt) begin
      err_cnt_r <= CNT_W'(err_s);
    end else if (err_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic             bit_s;
  logic [CNT_W-1:0] bit_cnt_r;

  assign bit_s = use_pred_s & chk.bit_valid;

  // Saturating count of bits checked while locked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (chk.clr_cnt) begin
      bit_cnt_r <= CNT_W'(bit_s);
    end else if (bit_s && (bit_cnt_r != CNT_MAX)) begin
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign chk.bit_cnt = bit_cnt_r;
`else
  assign chk.bit_cnt = {CNT_W{1'b0}};
`endif

  assign chk.locked     = locked_r;
  assign chk.err_pulse  = err_pulse_r;
  assign chk.lost_pulse = lost_pulse_r;
  assign chk.err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_prbs14_checker.sv
// Directed bench for prbs14_checker: scenario table plus hand-written reset/lockup sequences.
module tb_prbs14_checker;
  import prbs_pkg::*;

  localparam int CNT_W = 16;

  typedef struct {
    int nbits; int gap;
    int f0; int f0n; int f1; int f1n; int clr_bit;
    int e_first; int e_last; int e_errp; int e_lost; int e_errc; int e_bitc; int e_locked;
  } vec_t;

  logic clk;
  logic reset;
  prbs14_checker_if #(.CNT_W(CNT_W)) bus();

  prbs14_checker #(
    .LOCK_CNT(16), .WIN_LEN(64), .LOSS_THRESH(8), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .chk   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures;
  int n_errp, n_lost, first_lock, last_lock, cur_bit;
  logic prev_locked;
  logic [13:0] gen;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic gen_next(output logic b);
    b   = gen[8] ^ gen[10] ^ gen[12] ^ gen[13];
    gen = {gen[12:0], b};
  endtask

  task automatic clear_track();
    n_errp = 0; n_lost = 0; first_lock = 0; last_lock = 0; cur_bit = 0;
    prev_locked = 1'b0;
  endtask

  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clk);
    bus.bit_in = b; bus.bit_valid = v; bus.clr_cnt = clr;
    @(posedge clk);
    #1;
    if (bus.err_pulse) n_errp++;
    if (bus.lost_pulse) n_lost++;
    if (bus.locked && !prev_locked) begin
      if (first_lock == 0) first_lock = cur_bit;
      last_lock = cur_bit;
    end
    prev_locked = bus.locked;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_track();
    gen = PRBS_SEED;
  endtask

  task automatic feed(input int nbits, input int gap, input int f0, input int f0n,
                      input int f1, input int f1n, input int clr_bit);
    logic b, fl;
    for (int i = 1; i <= nbits; i++) begin
      gen_next(b);
      fl = ((i >= f0) && (i < f0 + f0n)) || ((i >= f1) && (i < f1 + f1n));
      cur_bit = i;
      step(b ^ fl, 1'b1, (i == clr_bit));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic int exp_bitcnt(input int v);
`ifdef PRBS_CHK_BITCNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clr_cnt = 1'b0;

    //            nbits gap  f0 f0n  f1 f1n clr  first last errp lost errc bitc lk
    vecs[0] = '{200, 0,    0, 0,    0, 0,  0,   30,  30,   0,  0,   0, 170, 1};
    vecs[1] = '{200, 0,  100, 1,    0, 0,  0,   30,  30,   1,  0,   1, 170, 1};
    vecs[2] = '{200, 0,  100, 8,    0, 0,  0,   30, 137,   8,  1,   8, 140, 1};
    vecs[3] = '{200, 0,   95, 7,  159, 7,  0,   30,  30,  14,  0,  14, 170, 1};
    vecs[4] = '{200, 0,  155, 4,  159, 4,  0,   30,  30,   8,  0,   8, 170, 1};
    vecs[5] = '{200, 0,  151, 8,    0, 0,  0,   30, 188,   8,  1,   8, 140, 1};
    vecs[6] = '{200, 0,   60, 1,  100, 1, 100,  30,  30,   2,  0,   1, 101, 1};
    vecs[7] = '{200, 2,    0, 0,    0, 0,  0,   30,  30,   0,  0,   0, 170, 1};

    do_reset();
    #1;
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_err_pulse", int'(bus.err_pulse), 0);
    chk("rst_lost_pulse", int'(bus.lost_pulse), 0);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    chk("rst_bit_cnt", int'(bus.bit_cnt), 0);

    for (int k = 0; k < 8; k++) begin
      do_reset();
      feed(vecs[k].nbits, vecs[k].gap, vecs[k].f0, vecs[k].f0n,
           vecs[k].f1, vecs[k].f1n, vecs[k].clr_bit);
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_first_lock", k), first_lock, vecs[k].e_first);
      chk($sformatf("v%0d_last_lock", k), last_lock, vecs[k].e_last);
      chk($sformatf("v%0d_err_pulses", k), n_errp, vecs[k].e_errp);
      chk($sformatf("v%0d_lost_pulses", k), n_lost, vecs[k].e_lost);
      chk($sformatf("v%0d_err_cnt", k), int'(bus.err_cnt), vecs[k].e_errc);
      chk($sformatf("v%0d_bit_cnt", k), int'(bus.bit_cnt), exp_bitcnt(vecs[k].e_bitc));
      chk($sformatf("v%0d_locked", k), int'(bus.locked), vecs[k].e_locked);
    end

    // All-zero lockup: zeros never lock, a clean stream afterwards does
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      cur_bit = i;
      step(1'b0, 1'b1, 1'b0);
    end
    chk("zeros_no_lock", first_lock, 0);
    chk("zeros_locked", int'(bus.locked), 0);
    clear_track();
    gen = PRBS_SEED;
    feed(60, 0, 0, 0, 0, 0, 0);
    chk("zeros_then_clean_lock_by_30", int'((first_lock >= 1) && (first_lock <= 30)), 1);
    chk("zeros_then_clean_locked", int'(bus.locked), 1);
    chk("zeros_then_clean_err_cnt", int'(bus.err_cnt), 0);

    // Reset while locked with five counted errors
    do_reset();
    feed(50, 0, 41, 5, 0, 0, 0);
    chk("pre_rst_err_cnt", int'(bus.err_cnt), 5);
    chk("pre_rst_bit_cnt", int'(bus.bit_cnt), exp_bitcnt(20));
    chk("pre_rst_locked", int'(bus.locked), 1);
    @(negedge clk);
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    #1;
    chk("mid_rst_locked", int'(bus.locked), 0);
    chk("mid_rst_err_cnt", int'(bus.err_cnt), 0);
    chk("mid_rst_bit_cnt", int'(bus.bit_cnt), 0);
    chk("mid_rst_err_pulse", int'(bus.err_pulse), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_lost_pulse", int'(bus.lost_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_track();
    gen = PRBS_SEED;
    feed(30, 0, 0, 0, 0, 0, 0);
    chk("post_rst_lock_bit", first_lock, 30);
    chk("post_rst_lost_pulses", n_lost, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
